sha256_msg_feeder: RTL and testbench
====================================

SHA256_MSG_FEEDER -- requirements
Module: sha256_msg_feeder

Interface
REQ-001 SHALL have the following ports, clock and reset first (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_data  in  32  message word, big-endian; first byte in [31:24].
- s_valid  in  1  s_data valid.
- s_ready  out  1  feeder accepts the word.
- s_last  in  1  final word of the message.
- s_bytes  in  3  valid bytes in the s_last word (1..4); 0 means an empty message; ignored when s_last=0.
- core_acc_reset  out  1  one-cycle pulse that reloads the core initial hash values.
- core_start  out  1  one-cycle block start.
- core_block  out  512  block; word i at [32i+31:32i].
- core_done  in  1  core block-complete pulse.
- core_digest  in  256  core chaining value; H0 at [255:224].
- d_valid  out  1  digest valid.
- d_data  out  256  final digest.
- d_ready  in  1  digest consumer ready.

Function
REQ-002 SHALL accept a word only on s_valid&&s_ready; s_ready=1 only in FILL.
REQ-003 SHALL implement states INIT, FILL, PADZ, LEN, START, WAIT, SETTLE, OUT.
REQ-004 INIT: assert core_acc_reset for one cycle; clear the word index and the 64-bit bit counter; next state FILL.
REQ-005 FILL: write the accepted word at the word index; add 32 to the bit counter (8*s_bytes on an s_last word); increment the index.
REQ-006 On an s_last word with s_bytes<4: mask the unused low bytes to 0 and place 0x80 in the first unused byte.
REQ-007 On an s_last word with s_bytes=4: place 0x80000000 in the next word slot. If that slot is index 16, it goes to word 0 of the next block.
REQ-008 s_bytes=0: treat as a zero-length message; write 0x80000000 at the current index; the bit counter is unchanged.
REQ-009 After padding: if the next free index is <=14, go to PADZ, zero-fill to index 13, then LEN.
REQ-010 After padding: if the next free index is >14, zero-fill to 15, hash the block as non-final, then build an extra block (zeros in words 0..13) followed by LEN.
REQ-011 LEN: word 14 = bit counter[63:32], word 15 = bit counter[31:0]; the bit counter wraps modulo 2^64.
REQ-012 A full 16-word block without s_last SHALL go to START as non-final.
REQ-013 START: core_start=1 for exactly one cycle; core_block stays stable from START until leaving SETTLE.
REQ-014 WAIT: hold until core_done=1, then go to SETTLE. core_done outside WAIT SHALL be ignored.
REQ-015 SETTLE (one cycle): for a final block, capture core_digest into d_data and go to OUT; otherwise clear the index and go to FILL, or go to the extra block per REQ-010.
REQ-016 OUT: d_valid=1 and d_data is held until d_ready; on the handshake go to INIT.
REQ-017 Latency: core_start is asserted 1 cycle after the 16th word is accepted (non-final); d_valid is asserted 2 cycles after the final core_done.
REQ-018 An s_valid word arriving while s_ready=0 SHALL be neither consumed nor lost.

Reset
REQ-019 reset SHALL force state INIT and drive s_ready=0, core_start=0, core_acc_reset=0, d_valid=0, d_data=0, core_block=0, index=0, bit counter=0. Reset mid-hash SHALL abandon the message; the INIT pulse reinitialises the core.

Structure
REQ-020 sha256_pkg SHALL hold the state enum, PAD_WORD=32'h80000000, and BLOCK_WORDS=16.
REQ-021 Sub-module sha256_pad_word SHALL combinationally produce the masked, 0x80-appended final word from s_data and s_bytes.
REQ-022 The bench SHALL connect the feeder to sha256_module.

Verification
REQ-023 "abc" (one word 0x61626300, s_bytes=3) -> one block; d_data=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-024 Empty message (s_last, s_bytes=0) -> d_data=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
REQ-025 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmjklmnklmnomnopnopq" -> two core_start pulses; d_data=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
REQ-026 64-byte message (s_last at index 15, s_bytes=4) -> second block word0=0x80000000, word15=0x00000200.
REQ-027 Random s_valid gaps and d_ready held low for 10 cycles -> identical digests; d_data stable while d_valid=1.
REQ-028 reset asserted during WAIT, then "abc" -> correct "abc" digest.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message feeder and its helpers.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FILL,
    ST_PADZ,
    ST_LEN,
    ST_START,
    ST_WAIT,
    ST_SETTLE,
    ST_OUT
  } state_e;

  localparam logic [31:0] PAD_WORD    = 32'h8000_0000;
  localparam int          BLOCK_WORDS = 16;

  // Message bits contributed by a final word; 4..7 all count as a full word.
  function automatic logic [63:0] last_word_bits(input logic [2:0] bytes);
    return bytes[2] ? 64'd32 : {58'd0, bytes, 3'b000};
  endfunction

endpackage

// File: rtl/sha256_msg_feeder_if.sv
// Bundles the message stream, core control and digest output of the feeder.
interface sha256_msg_feeder_if;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_ready;
  logic         s_last;
  logic [2:0]   s_bytes;
  logic         core_acc_reset;
  logic         core_start;
  logic [511:0] core_block;
  logic         core_done;
  logic [255:0] core_digest;
  logic         d_valid;
  logic [255:0] d_data;
  logic         d_ready;

  modport master (
    input  s_data, s_valid, s_last, s_bytes, core_done, core_digest, d_ready,
    output s_ready, core_acc_reset, core_start, core_block, d_valid, d_data
  );

  modport slave (
    output s_data, s_valid, s_last, s_bytes, core_done, core_digest, d_ready,
    input  s_ready, core_acc_reset, core_start, core_block, d_valid, d_data
  );
endinterface

// File: rtl/sha256_module.sv
// Iterative SHA-256 compression core: one round per clock, 64 rounds per
// block, chaining value accumulated across blocks until acc_reset.
module sha256_module (
  input  logic         clk,
  input  logic         reset,
  input  logic         acc_reset,
  input  logic         start,
  input  logic [511:0] block,
  output logic         done,
  output logic [255:0] digest
);

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  logic [31:0] h  [8];
  logic [31:0] v  [8];
  logic [31:0] nv [8];
  logic [31:0] w  [16];
  logic [31:0] w_new, t1, t2;
  logic [5:0]  rnd;
  logic        busy;

  // w[0] is the schedule word of the current round; w[15] is 15 rounds ahead.
  always_comb begin
    t1    = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[rnd] + w[0];
    t2    = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    w_new = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
    nv[0] = t1 + t2;
    nv[1] = v[0];
    nv[2] = v[1];
    nv[3] = v[2];
    nv[4] = v[3] + t1;
    nv[5] = v[4];
    nv[6] = v[5];
    nv[7] = v[6];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      rnd  <= '0;
      for (int i = 0; i < 8; i++) h[i] <= IV[i];
    end else begin
      done <= 1'b0;
      if (acc_reset) begin
        busy <= 1'b0;
        for (int i = 0; i < 8; i++) h[i] <= IV[i];
      end else if (busy) begin
        for (int i = 0; i < 8; i++) v[i] <= nv[i];
        for (int i = 0; i < 15; i++) w[i] <= w[i+1];
        w[15] <= w_new;
        rnd   <= rnd + 6'd1;
        if (rnd == 6'd63) begin
          busy <= 1'b0;
          done <= 1'b1;
          for (int i = 0; i < 8; i++) h[i] <= h[i] + nv[i];
        end
      end else if (start) begin
        busy <= 1'b1;
        rnd  <= '0;
        for (int i = 0; i < 8; i++) v[i] <= h[i];
        for (int i = 0; i < 16; i++) w[i] <= block[32*i +: 32];
      end
    end
  end

  assign digest = {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};

endmodule

// File: rtl/sha256_pad_word.sv
// Final-word formatter: keeps the valid leading bytes, zeroes the rest and
// appends the 0x80 marker directly after the last message byte.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  bytes,
  output logic [31:0] word
);

  always_comb begin
    word = data;
    case (bytes)
      3'd0:    word = PAD_WORD;
      3'd1:    word = {data[31:24], 24'h80_0000};
      3'd2:    word = {data[31:16], 16'h8000};
      3'd3:    word = {data[31:8], 8'h80};
      default: word = data;
    endcase
  end

endmodule

// File: rtl/sha256_msg_feeder.sv
// Packs a byte-granular word stream into padded 512-bit SHA-256 blocks,
// sequences the compression core and presents the final digest.
module sha256_msg_feeder
  import sha256_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  sha256_msg_feeder_if.master  bus
);

  state_e                         state, state_nxt;
  logic [3:0]                     idx;
  logic [63:0]                    bit_cnt;
  logic [BLOCK_WORDS-1:0][31:0]   block;
  logic [255:0]                   digest;
  logic                           final_blk, extra_blk, wrap_pad;
  logic                           accept, last_full;
  logic [31:0]                    pad_word;

  sha256_pad_word u_pad (
    .data  (bus.s_data),
    .bytes (bus.s_bytes),
    .word  (pad_word)
  );

  assign accept    = (state == ST_FILL) && bus.s_valid && !reset;
  assign last_full = bus.s_bytes[2];

  always_ff @(posedge clk) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    bus.s_ready        = 1'b0;
    bus.core_acc_reset = 1'b0;
    bus.core_start     = 1'b0;
    bus.d_valid        = 1'b0;
    case (state)
      ST_INIT: state_nxt = ST_FILL;
      ST_FILL: begin
        if (accept) begin
          if (!bus.s_last)    state_nxt = (idx == 4'd15) ? ST_START : ST_FILL;
          else if (last_full) state_nxt = (idx <= 4'd12) ? ST_PADZ : ST_START;
          else                state_nxt = (idx <= 4'd13) ? ST_PADZ : ST_START;
        end
      end
      ST_PADZ:   state_nxt = (idx >= 4'd13) ? ST_LEN : ST_PADZ;
      ST_LEN:    state_nxt = ST_START;
      ST_START:  state_nxt = ST_WAIT;
      ST_WAIT:   if (bus.core_done) state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (final_blk)      state_nxt = ST_OUT;
        else if (extra_blk) state_nxt = ST_PADZ;
        else                state_nxt = ST_FILL;
      end
      ST_OUT:    if (bus.d_ready) state_nxt = ST_INIT;
      default:   state_nxt = ST_INIT;
    endcase
    // Outputs are gated by reset so they read idle while it is held.
    bus.s_ready        = (state == ST_FILL)  && !reset;
    bus.core_acc_reset = (state == ST_INIT)  && !reset;
    bus.core_start     = (state == ST_START) && !reset;
    bus.d_valid        = (state == ST_OUT)   && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      bit_cnt   <= '0;
      block     <= '0;
      digest    <= '0;
      final_blk <= 1'b0;
      extra_blk <= 1'b0;
      wrap_pad  <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          idx       <= '0;
          bit_cnt   <= '0;
          final_blk <= 1'b0;
          extra_blk <= 1'b0;
          wrap_pad  <= 1'b0;
        end
        ST_FILL: begin
          if (accept) begin
            block[idx] <= bus.s_last ? pad_word : bus.s_data;
            if (!bus.s_last) begin
              bit_cnt <= bit_cnt + 64'd32;
              idx     <= idx + 4'd1;
            end else begin
              bit_cnt <= bit_cnt + last_word_bits(bus.s_bytes);
              if (last_full) begin
                // The marker word spills into the next block when idx is 15.
                if (idx == 4'd15) begin
                  wrap_pad  <= 1'b1;
                  extra_blk <= 1'b1;
                end else begin
                  block[idx + 4'd1] <= PAD_WORD;
                  if (idx <= 4'd12) idx <= idx + 4'd2;
                  else begin
                    extra_blk <= 1'b1;
                    if (idx == 4'd13) block[15] <= '0;
                  end
                end
              end else if (idx <= 4'd13) begin
                idx <= idx + 4'd1;
              end else begin
                extra_blk <= 1'b1;
                if (idx == 4'd14) block[15] <= '0;
              end
            end
          end
        end
        ST_PADZ: begin
          if (idx <= 4'd13) block[idx] <= '0;
          if (idx <= 4'd12) idx <= idx + 4'd1;
        end
        ST_LEN: begin
          block[14] <= bit_cnt[63:32];
          block[15] <= bit_cnt[31:0];
          final_blk <= 1'b1;
        end
        ST_SETTLE: begin
          if (final_blk) begin
            digest <= bus.core_digest;
          end else if (extra_blk) begin
            extra_blk <= 1'b0;
            wrap_pad  <= 1'b0;
            if (wrap_pad) begin
              block[0] <= PAD_WORD;
              idx      <= 4'd1;
            end else begin
              idx <= '0;
            end
          end else begin
            idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.core_block = block;
  assign bus.d_data     = digest;

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Directed bench: feeder plus compression core against known SHA-256 vectors.
module tb_sha256_msg_feeder;

  localparam logic [255:0] DG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DG_56    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sha256_msg_feeder_if bus ();

  sha256_msg_feeder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  sha256_module core (
    .clk       (clk),
    .reset     (reset),
    .acc_reset (bus.core_acc_reset),
    .start     (bus.core_start),
    .block     (bus.core_block),
    .done      (bus.core_done),
    .digest    (bus.core_digest)
  );

  int           errs = 0;
  int           checks = 0;
  int           cyc = 0;
  int           n_starts = 0;
  int           done_cyc = 0;
  logic [2:0]   slot = '0;
  logic [511:0] blocks [8];
  logic [255:0] dg;
  int           base;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.core_start) begin
      blocks[slot] <= bus.core_block;
      slot         <= slot + 3'd1;
      n_starts     <= n_starts + 1;
    end
    if (bus.core_done) done_cyc <= cyc;
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] wd(input logic [511:0] b, input int i);
    return 512'(b[32*i +: 32]);
  endfunction

  task automatic send_word(input logic [31:0] data, input logic last, input logic [2:0] bytes, input int gap);
    logic acc;
    acc = 1'b0;
    bus.s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.s_data  = data;
    bus.s_last  = last;
    bus.s_bytes = bytes;
    bus.s_valid = 1'b1;
    for (int t = 0; t < 500 && !acc; t++) begin
      acc = bus.s_ready;
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    if (!acc) check("s_ready timeout", 512'(acc), 512'(1));
  endtask

  task automatic recv(input int hold, output logic [255:0] digest);
    logic seen, stable;
    seen   = 1'b0;
    stable = 1'b1;
    digest = '0;
    for (int t = 0; t < 3000 && !seen; t++) begin
      if (bus.d_valid) seen = 1'b1;
      else @(negedge clk);
    end
    check("d_valid seen", 512'(seen), 512'(1));
    if (seen) begin
      check("d_valid latency", 512'(cyc), 512'(done_cyc + 2));
      digest = bus.d_data;
      repeat (hold) begin
        @(negedge clk);
        if (!bus.d_valid || bus.d_data !== digest) stable = 1'b0;
      end
      if (hold > 0) check("d_data hold", 512'(stable), 512'(1));
      bus.d_ready = 1'b1;
      @(negedge clk);
      bus.d_ready = 1'b0;
      check("d_valid drop", 512'(bus.d_valid), 512'(0));
    end
  endtask

  task automatic send_msg56(input int gap_max);
    logic [7:0] c;
    for (int i = 0; i < 14; i++) begin
      c = 8'(97 + i);
      send_word({c, c + 8'd1, c + 8'd2, c + 8'd3}, (i == 13), 3'd4,
                int'($urandom_range(gap_max, 0)));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  initial begin
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_bytes = '0;
    bus.d_ready = 1'b0;
    repeat (3) @(negedge clk);

    check("rst s_ready",    512'(bus.s_ready),        512'(0));
    check("rst core_start", 512'(bus.core_start),     512'(0));
    check("rst acc_reset",  512'(bus.core_acc_reset), 512'(0));
    check("rst d_valid",    512'(bus.d_valid),        512'(0));
    check("rst d_data",     512'(bus.d_data),         512'(0));
    check("rst core_block", bus.core_block,           512'(0));
    reset = 1'b0;
    #1;
    check("init acc_reset", 512'(bus.core_acc_reset), 512'(1));
    @(negedge clk);
    check("fill s_ready",   512'(bus.s_ready),        512'(1));
    check("fill acc_reset", 512'(bus.core_acc_reset), 512'(0));

    // "abc"
    base = n_starts;
    send_word(32'h61626300, 1'b1, 3'd3, 0);
    recv(0, dg);
    check("abc digest", 512'(dg), 512'(DG_ABC));
    check("abc starts", 512'(n_starts - base), 512'(1));
    check("abc w0",  wd(blocks[3'(base)], 0),  512'(32'h61626380));
    check("abc w13", wd(blocks[3'(base)], 13), 512'(0));
    check("abc w15", wd(blocks[3'(base)], 15), 512'(32'h18));

    // Empty message; data lanes carry junk that must be discarded.
    base = n_starts;
    send_word(32'hdeadbeef, 1'b1, 3'd0, 0);
    recv(0, dg);
    check("empty digest", 512'(dg), 512'(DG_EMPTY));
    check("empty w0",  wd(blocks[3'(base)], 0),  512'(32'h80000000));
    check("empty w15", wd(blocks[3'(base)], 15), 512'(0));

    // 56-byte message: padding forces an extra length-only block.
    base = n_starts;
    send_msg56(0);
    recv(0, dg);
    check("m56 digest", 512'(dg), 512'(DG_56));
    check("m56 starts", 512'(n_starts - base), 512'(2));
    check("m56 b0 w13", wd(blocks[3'(base)], 13), 512'(32'h6e6f7071));
    check("m56 b0 w14", wd(blocks[3'(base)], 14), 512'(32'h80000000));
    check("m56 b0 w15", wd(blocks[3'(base)], 15), 512'(0));
    check("m56 b1 w0",  wd(blocks[3'(base + 1)], 0),  512'(0));
    check("m56 b1 w15", wd(blocks[3'(base + 1)], 15), 512'(32'h1c0));

    // 64-byte message: marker wraps into word 0 of the second block.
    base = n_starts;
    for (int i = 0; i < 16; i++) begin
      send_word({4{8'(i)}}, (i == 15), 3'd4, 0);
      if (i == 15) begin
        check("m64 start latency", 512'(bus.core_start), 512'(1));
        check("m64 b0 w15", wd(bus.core_block, 15), 512'(32'h0f0f0f0f));
      end
    end
    recv(0, dg);
    check("m64 starts", 512'(n_starts - base), 512'(2));
    check("m64 b1 w0",  wd(blocks[3'(base + 1)], 0),  512'(32'h80000000));
    check("m64 b1 w1",  wd(blocks[3'(base + 1)], 1),  512'(0));
    check("m64 b1 w14", wd(blocks[3'(base + 1)], 14), 512'(0));
    check("m64 b1 w15", wd(blocks[3'(base + 1)], 15), 512'(32'h200));

    // Same 56-byte message with input gaps and a stalled consumer.
    send_msg56(3);
    recv(10, dg);
    check("gap digest", 512'(dg), 512'(DG_56));

    // Reset while the core is busy on a non-final block.
    for (int i = 0; i < 16; i++) begin
      send_word(32'h01234567 + 32'(i), 1'b0, 3'd0, 0);
      if (i == 15) check("nonfinal start latency", 512'(bus.core_start), 512'(1));
    end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst s_ready",    512'(bus.s_ready),        512'(0));
    check("midrst d_valid",    512'(bus.d_valid),        512'(0));
    check("midrst acc_reset",  512'(bus.core_acc_reset), 512'(0));
    check("midrst core_block", bus.core_block,           512'(0));
    reset = 1'b0;
    #1;
    check("midrst init pulse", 512'(bus.core_acc_reset), 512'(1));
    @(negedge clk);
    send_word(32'h61626300, 1'b1, 3'd3, 0);
    recv(0, dg);
    check("post-reset abc digest", 512'(dg), 512'(DG_ABC));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
